// File: rtl/quaffle_controller.sv
// quaffle_controller: per-frame ball motion, wall/paddle bounces, scoring and game-over for the VGA pong field
module quaffle_controller #(
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int PADDLE_H     = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [9:0] team1_ver_pos,
  input  logic [9:0] team2_ver_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_visible,
  output logic [3:0] team1_score,
  output logic [3:0] team2_score,
  output logic       game_over
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic dx_pos, dy_pos, dx_nx, dy_nx, vis_nx, over_nx;
  logic [9:0] x_nx, y_nx;
  logic [3:0] s1_nx, s2_nx;
  logic [10:0] x11, y11, p1, p2;
  logic ov1, ov2, edge_r, edge_l, miss;
  assign x11 = {1'b0, ball_x};
  assign y11 = {1'b0, ball_y};
  assign p1 = {1'b0, team1_ver_pos};
  assign p2 = {1'b0, team2_ver_pos};
  // 11-bit arithmetic so off-screen paddle positions cannot wrap into an overlap
  assign ov1 = (y11 + 11'd8 > p1) && (y11 < p1 + 11'(PADDLE_H));
  assign ov2 = (y11 + 11'd8 > p2) && (y11 < p2 + 11'(PADDLE_H));
  assign edge_r = x11 + 11'(SPEED) > 11'd608;
  assign edge_l = x11 < 11'(24 + SPEED);
  assign miss = dx_pos ? edge_r && !ov2 : edge_l && !ov1;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    x_nx = ball_x;
    y_nx = ball_y;
    dx_nx = dx_pos;
    dy_nx = dy_pos;
    vis_nx = ball_visible;
    over_nx = game_over;
    s1_nx = team1_score;
    s2_nx = team2_score;
    if (frame_tick) begin
      case (state)
        SERVE: begin
          state_nx = (cnt == CW'(SERVE_FRAMES - 1)) ? PLAY : SERVE;
          cnt_nx = (cnt == CW'(SERVE_FRAMES - 1)) ? '0 : cnt + CW'(1);
        end
        PLAY: begin
          if (miss) begin
            state_nx = SCORED;
            vis_nx = 1'b0;
            s1_nx = dx_pos ? team1_score + 4'd1 : team1_score;
            s2_nx = dx_pos ? team2_score : team2_score + 4'd1;
          end else begin
            if (dy_pos) begin
              y_nx = (y11 + 11'(SPEED) > 11'd472) ? 10'd472 : ball_y + 10'(SPEED);
              dy_nx = !(y11 + 11'(SPEED) > 11'd472);
            end else begin
              y_nx = (ball_y < 10'(SPEED)) ? 10'd0 : ball_y - 10'(SPEED);
              dy_nx = ball_y < 10'(SPEED);
            end
            if (dx_pos) begin
              x_nx = edge_r ? 10'd608 : ball_x + 10'(SPEED);
              dx_nx = !edge_r;
            end else begin
              x_nx = edge_l ? 10'd24 : ball_x - 10'(SPEED);
              dx_nx = edge_l;
            end
          end
        end
        SCORED: begin
          // dx still points at the team that conceded, so the serve heads toward them
          if (team1_score == 4'(WIN_SCORE) || team2_score == 4'(WIN_SCORE)) begin
            state_nx = OVER;
            over_nx = 1'b1;
          end else begin
            state_nx = SERVE;
            vis_nx = 1'b1;
            x_nx = 10'd316;
            y_nx = 10'd236;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SERVE;
      cnt <= '0;
      ball_x <= 10'd316;
      ball_y <= 10'd236;
      dx_pos <= 1'b1;
      dy_pos <= 1'b1;
      ball_visible <= 1'b1;
      game_over <= 1'b0;
      team1_score <= 4'd0;
      team2_score <= 4'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ball_x <= x_nx;
      ball_y <= y_nx;
      dx_pos <= dx_nx;
      dy_pos <= dy_nx;
      ball_visible <= vis_nx;
      game_over <= over_nx;
      team1_score <= s1_nx;
      team2_score <= s2_nx;
    end
  end
endmodule

// File: tb/tb_quaffle_controller.sv
// tb_quaffle_controller: random frame ticks and paddle positions against a velocity-based game model
module tb_quaffle_controller;
  localparam int SPEED = 2, SF = 60, WIN = 2, PH = 64;
  localparam int P_SERVE = 0, P_PLAY = 1, P_SCORED = 2, P_OVER = 3;
  logic clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0;
  logic [9:0] team1_ver_pos = '0, team2_ver_pos = '0;
  logic [9:0] ball_x, ball_y;
  logic ball_visible, game_over;
  logic [3:0] team1_score, team2_score;
  quaffle_controller #(.SPEED(SPEED), .SERVE_FRAMES(SF), .WIN_SCORE(WIN), .PADDLE_H(PH)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .team1_ver_pos(team1_ver_pos), .team2_ver_pos(team2_ver_pos),
    .ball_x(ball_x), .ball_y(ball_y), .ball_visible(ball_visible),
    .team1_score(team1_score), .team2_score(team2_score), .game_over(game_over)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [9:0] x, y;
    logic vis;
    logic [3:0] s1, s2;
    logic over;
  } exp_t;
  exp_t q[$];
  exp_t e, got;
  int checks = 0, failures = 0;
  int mx, my, vx, vy, s1, s2, cnt, ph;
  function automatic bit overlap(int y, int p);
    return (y + 8 > p) && (y < p + PH);
  endfunction
  function void model_reset();
    mx = 316; my = 236; vx = SPEED; vy = SPEED;
    s1 = 0; s2 = 0; cnt = 0; ph = P_SERVE;
  endfunction
  function void model_tick(int p1, int p2);
    int nx, ny, nvx, nvy;
    bit mis;
    case (ph)
      P_SERVE: if (cnt == SF - 1) begin cnt = 0; ph = P_PLAY; end else cnt++;
      P_PLAY: begin
        nx = mx + vx; ny = my + vy; nvx = vx; nvy = vy; mis = 0;
        if (ny > 472) begin ny = 472; nvy = -vy; end
        else if (ny < 0) begin ny = 0; nvy = -vy; end
        if (nx > 608) begin
          if (overlap(my, p2)) begin nx = 608; nvx = -vx; end else mis = 1;
        end else if (nx < 24) begin
          if (overlap(my, p1)) begin nx = 24; nvx = -vx; end else mis = 1;
        end
        if (mis) begin
          if (vx > 0) s1++; else s2++;
          ph = P_SCORED;
        end else begin
          mx = nx; my = ny; vx = nvx; vy = nvy;
        end
      end
      P_SCORED: begin
        if (s1 == WIN || s2 == WIN) ph = P_OVER;
        else begin ph = P_SERVE; mx = 316; my = 236; end
      end
      default: ;
    endcase
  endfunction
  function automatic int pad(int y);
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1023);
    v = y - 64 + $urandom_range(0, 72);
    return v < 0 ? 0 : (v > 1023 ? 1023 : v);
  endfunction
  task automatic step(input logic rst_n, input logic tick, input int p1, input int p2);
    exp_t x;
    reset_n = rst_n; frame_tick = tick;
    team1_ver_pos = 10'(p1); team2_ver_pos = 10'(p2);
    @(posedge clk);
    if (!rst_n) model_reset(); else if (tick) model_tick(p1, p2);
    x.x = 10'(mx); x.y = 10'(my);
    x.vis = (ph == P_SERVE || ph == P_PLAY);
    x.s1 = 4'(s1); x.s2 = 4'(s2);
    x.over = (ph == P_OVER);
    q.push_back(x);
    #1;
  endtask
  task automatic play(input int n, input int tick_pct);
    for (int i = 0; i < n; i++)
      step(1'b1, $urandom_range(0, 99) < tick_pct, pad(my), pad(my));
  endtask
  task automatic chk(input bit ok, input string name);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s t=%0t x=%0d y=%0d vis=%0b s1=%0d s2=%0d over=%0b",
               name, $time, ball_x, ball_y, ball_visible, team1_score, team2_score, game_over);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {ball_x, ball_y, ball_visible, team1_score, team2_score, game_over};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ball_state t=%0t got x=%0d y=%0d vis=%0b s1=%0d s2=%0d over=%0b required x=%0d y=%0d vis=%0b s1=%0d s2=%0d over=%0b",
                 $time, got.x, got.y, got.vis, got.s1, got.s2, got.over, e.x, e.y, e.vis, e.s1, e.s2, e.over);
      end
    end
  end
  initial begin
    model_reset();
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 60000 && ph != P_OVER; i++)
      step(1'b1, $urandom_range(0, 3) != 0, pad(my), pad(my));
    play(40, 80);
    step(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < SF + 50; i++) step(1'b1, 1'b1, pad(my), pad(my));
    step(1'b0, 1'b1, 400, 400);
    play(400, 70);
    step(1'b0, 1'b1, 0, 0);
    play(20, 100);
    step(1'b0, 1'b1, 0, 0);
    chk(ball_x === 10'd316 && ball_y === 10'd236 && ball_visible === 1'b1 &&
        team1_score === 4'd0 && team2_score === 4'd0 && game_over === 1'b0, "reset_state");
    repeat (SF) step(1'b1, 1'b1, 0, 0);
    chk(ball_x === 10'd316 && ball_y === 10'd236 && ball_visible === 1'b1, "serve_wait_expired");
    step(1'b1, 1'b1, 0, 0);
    chk(ball_x === 10'd318 && ball_y === 10'd238 && ball_visible === 1'b1, "first_move");
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quaffle_controller.md
# quaffle_controller

Game-logic stage feeding the VGA controller: moves the quaffle (ball) once per video frame, bounces it off the top/bottom walls and the two team paddles, detects misses, keeps score and declares a winner. It consumes the team1/team2 vertical paddle positions produced by the team controllers. It drives ball position, visibility, scores and game-over flag into the VGA controller alongside the paddle positions.

## Interface

- SPEED, 2: pixels moved per frame on each axis (1..7)
- SERVE_FRAMES, 60: frames the ball waits at centre before play resumes
- WIN_SCORE, 7: score that ends the game (1..15)
- PADDLE_H, 64: paddle height in lines; paddle width fixed at 8

- clk  in  1  system clock (50 MHz)
- reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blanking
- team1_ver_pos  in  10  team1 paddle top line; paddle occupies x 16..23
- team2_ver_pos  in  10  team2 paddle top line; paddle occupies x 616..623
- ball_x  out  10  ball left column; ball is 8x8 pixels
- ball_y  out  10  ball top line
- ball_visible  out  1  ball is drawn
- team1_score  out  4  team1 points
- team2_score  out  4  team2 points
- game_over  out  1  a team reached WIN_SCORE

## Operation

- Visible field 640x480. Legal ball_y range 0..472.
- Direction held as two sign bits: dx_pos, dy_pos.
- States: SERVE, PLAY, SCORED, OVER. All state/position updates happen only on cycles with frame_tick=1; no other cycle changes anything.
- SERVE: ball at (316,236), visible. Frame counter increments per tick. On the tick where counter reaches SERVE_FRAMES-1, counter clears and the state goes to PLAY. The ball does not move in that tick.
- PLAY, per tick:
  - Vertical: compute ny = y ± SPEED.
    - If dy_pos and y+SPEED > 472, then y=472 and dy_pos=0.
    - If !dy_pos and y < SPEED, then y=0 and dy_pos=1.
    - Otherwise y=ny.
  - Horizontal, moving right: if x+SPEED > 608, test overlap with team2 using current y.
    - Overlap means y+8 > team2_ver_pos and y < team2_ver_pos+PADDLE_H.
    - Hit: x=608, dx_pos=0.
    - Miss: team1_score+1, go to SCORED.
    - Otherwise x=x+SPEED.
  - Horizontal, moving left: mirror of the above with threshold x < 24+SPEED, clamp x=24, team1 paddle; a miss credits team2.
  - The vertical and horizontal rules apply together in the same tick. A corner hit flips both sign bits.
  - On a miss, position is not updated.
- Paddle positions are sampled only on frame_tick. Values ≥480 never overlap except through the arithmetic above; compute in 11 bits with no wrap.
- SCORED: lasts one tick with ball_visible=0. Next tick:
  - If the incremented score equals WIN_SCORE, go to OVER.
  - Otherwise go to SERVE with the ball at centre and dx_pos pointing toward the team that conceded. dy_pos is kept.
- OVER: game_over=1, ball_visible=0, scores frozen, frame_tick ignored. Exit only via reset.
- Scores never exceed WIN_SCORE.

## Timing

- Reset values: ball_x=316, ball_y=236, dx_pos=1, dy_pos=1, ball_visible=1, team1_score=0, team2_score=0, game_over=0, state SERVE, counter 0.
- All outputs are registered. They change on the clk edge that samples frame_tick=1 and are valid the following cycle.
- A reset asserted on a frame_tick cycle wins. Reset mid-game restores every reset value in one cycle.
- Latency is one tick per state transition. Serve to first movement: SERVE_FRAMES+1 ticks.

## Test plan

- Serve: reset, 60 ticks → still (316,236) in PLAY. Tick 61 (PLAY tick 1) → (318,238).
- Wall bounce: both paddles held at 400.
  - PLAY tick 118 → y=472, x=552.
  - Tick 119 → y=472 with dy flipped, x=554.
  - Tick 120 → y=470, x=556.
- Paddle hit: team2_ver_pos=400.
  - PLAY tick 146 → x=608, y=418.
  - Tick 147 → x=608, dx left.
  - Tick 148 → x=606, y=414. Scores unchanged.
- Miss: team2_ver_pos=0.
  - PLAY tick 147 → team1_score=1 and ball_visible=0 on the following cycle.
  - Next tick → SERVE, ball at (316,236), dx toward team2.
- Game over: WIN_SCORE=2, repeat the miss test → after the 2nd miss plus one tick, game_over=1, team1_score=2. Further ticks change nothing.
- Reset mid-play: assert reset_n=0 on a frame_tick cycle at PLAY tick 50 → all outputs return to reset values the next cycle.
